ray_setup_invdir: RTL and testbench
===================================

Name: ray_setup_invdir

Overview:
- Sequential ray-setup producer that feeds the AABB slab-test units.
- Accepts a ray (origin, direction, t range, primitive index) and computes the per-axis fixed-point reciprocal direction (InvDir).
- Emits a complete Ray record via a valid/ready handshake to the AABB/BVH traversal stage.
- Uses one shared iterative restoring divider across the three axes, giving a fixed, deterministic latency.

Parameters:
- WIDTH, 32, fixed-point word width (Fixed.Value width).
- FRAC, 16, fractional bits of the fixed-point format.
- PI_WIDTH, 16, primitive index width; MSB set means null primitive.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  input ray valid.
- in_ready  out  1  block can accept a ray.
- in_orig  in  3*WIDTH  origin {z,y,x}, signed fixed.
- in_dir  in  3*WIDTH  direction {z,y,x}, signed fixed.
- in_min_t  in  WIDTH  ray MinT.
- in_max_t  in  WIDTH  ray MaxT; MSB set means unbounded.
- in_pi  in  PI_WIDTH  originating primitive index.
- out_valid  out  1  output ray valid.
- out_ready  in  1  consumer accepts the output ray.
- out_orig, out_dir  out  3*WIDTH each  registered copies of the inputs.
- out_invdir  out  3*WIDTH  reciprocal direction {z,y,x}.
- out_min_t, out_max_t  out  WIDTH each  registered copies of the inputs.
- out_pi  out  PI_WIDTH  registered copy of in_pi.

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to IDLE.
  - in_ready=0 while resetn is low, and 1 from the first clock edge after release.
  - out_valid=0, and all out_* data outputs are 0.
  - Reset in the middle of a division aborts it; no partial output is produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch all inputs, set axis=0 and bit counter=0, go to DIV.
  - DIV: in_ready=0. Restoring division produces one quotient bit per clock, WIDTH clocks per axis, axes in order x,y,z. After axis z, bit WIDTH-1, go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE; out_valid falls on that edge.
- Latency and throughput:
  - out_valid rises exactly 3*WIDTH+1 clock edges after the accepting edge (97 for WIDTH=32).
  - There is no same-cycle accept on the DONE→IDLE transition, so throughput is one ray per 3*WIDTH+2 clocks minimum.
- Arithmetic, per axis, with d = dir raw value:
  - m = |d| (d = -2^(WIDTH-1) is treated as magnitude 2^(WIDTH-1)).
  - q = floor(2^(2*FRAC) / m), computed on the magnitude.
  - Result = q if d ≥ 0, otherwise -q; this truncates toward zero.
- Saturation:
  - Saturate if m ≤ 2^(2*FRAC-WIDTH+1). This includes m=0, and with default parameters it means m ≤ 2.
  - Saturated result is +(2^(WIDTH-1)-1) when d ≥ 0 (so d=0 gives positive) and -(2^(WIDTH-1)-1) when d < 0.
  - A saturated axis still consumes its full WIDTH clocks, keeping latency fixed.
- Pass-through fields (orig, dir, min_t, max_t, pi) are captured at accept and are not modified.
- in_valid while busy is ignored; it is the upstream's job to hold it.
- out_ready while not in DONE has no effect.

Optional Feature:
- Macro: RAYSETUP_PERF_CNT_EN.
- When defined, two extra output ports are added, both reset to 0 and wrapping modulo 2^32:
  - perf_rays (out, 32): increments on each out_valid&&out_ready.
  - perf_sat (out, 32): increments once per saturated axis, at that axis's final bit.
- When undefined, neither port nor either counter exists, and behaviour is otherwise identical.

Test Plan:
- Basic reciprocal: dir=(65536,-131072,32768) [1.0,-2.0,0.5], out_ready=1 → out_invdir=(65536,-32768,131072), out_valid exactly 97 clocks after accept.
- Zero/sign saturation: dir=(0,-1,2) → invdir=(0x7FFFFFFF,0x80000001,0x7FFFFFFF); dir x raw 3 → 1431655765; with RAYSETUP_PERF_CNT_EN, perf_sat=3 after this ray.
- Backpressure: out_ready=0 for 20 clocks after out_valid → all outputs stable, in_ready=0; raise out_ready → out_valid falls next edge, in_ready=1 the following cycle.
- Pass-through: orig=(1,2,3), min_t=0x00010000, max_t=0x80000000, pi=0x0005 → identical values on out_*.
- Reset mid-operation: assert resetn=0 at clock 40 of a division → out_valid=0 and in_ready=0 immediately; after release a new ray with dir=(65536,65536,65536) yields invdir=(65536,65536,65536) with full 97-clock latency.
- Back-to-back: 3 rays offered continuously with out_ready=1 → accepts spaced exactly 98 clocks apart, results in order; perf_rays=3.

Source files
------------

// File: rtl/ray_setup_invdir_if.sv
// ray_setup_invdir_if: ray input/output valid-ready bundle for the ray setup stage
interface ray_setup_invdir_if #(
  parameter int WIDTH    = 32,
  parameter int PI_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3*WIDTH-1:0]    in_orig;
  logic [3*WIDTH-1:0]    in_dir;
  logic [WIDTH-1:0]      in_min_t;
  logic [WIDTH-1:0]      in_max_t;
  logic [PI_WIDTH-1:0]   in_pi;
  logic                  out_valid;
  logic                  out_ready;
  logic [3*WIDTH-1:0]    out_orig;
  logic [3*WIDTH-1:0]    out_dir;
  logic [3*WIDTH-1:0]    out_invdir;
  logic [WIDTH-1:0]      out_min_t;
  logic [WIDTH-1:0]      out_max_t;
  logic [PI_WIDTH-1:0]   out_pi;
  modport master (
    output in_valid, in_orig, in_dir, in_min_t, in_max_t, in_pi, out_ready,
    input  in_ready, out_valid, out_orig, out_dir, out_invdir, out_min_t, out_max_t, out_pi
  );
  modport slave (
    input  in_valid, in_orig, in_dir, in_min_t, in_max_t, in_pi, out_ready,
    output in_ready, out_valid, out_orig, out_dir, out_invdir, out_min_t, out_max_t, out_pi
  );
endinterface

// File: rtl/ray_setup_invdir.sv
// ray_setup_invdir: per-axis fixed-point reciprocal direction via one shared restoring divider; RAYSETUP_PERF_CNT_EN adds perf_rays/perf_sat
module ray_setup_invdir #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 16,
  parameter int PI_WIDTH = 16
) (
  input  logic clk,
  input  logic resetn,
  ray_setup_invdir_if.slave rs
`ifdef RAYSETUP_PERF_CNT_EN
  ,
  output logic [31:0] perf_rays,
  output logic [31:0] perf_sat
`endif
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  localparam logic [2*WIDTH-1:0] DIVIDEND = {{(2*WIDTH-1){1'b0}}, 1'b1} << (2*FRAC);
  localparam logic [WIDTH-1:0] REM0 = DIVIDEND[2*WIDTH-1:WIDTH];
  localparam logic [WIDTH-1:0] DLO = DIVIDEND[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_LIM = WIDTH'(DIVIDEND >> (WIDTH-1));
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  state_t              state_q, state_d;
  logic                alive_q;
  logic [1:0]          axis_q, axis_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [3*WIDTH-1:0]  orig_q, orig_d, dir_q, dir_d, invdir_q, invdir_d;
  logic [WIDTH-1:0]    min_t_q, min_t_d, max_t_q, max_t_d;
  logic [PI_WIDTH-1:0] pi_q, pi_d;
  logic [WIDTH-1:0]    d_ax, mag, qfin, mres, res;
  logic [WIDTH:0]      trial;
  logic [CW-1:0]       bidx;
  logic                neg, sat, ge, last, accept;
  assign d_ax   = dir_q[WIDTH*axis_q +: WIDTH];
  assign neg    = d_ax[WIDTH-1];
  assign mag    = neg ? -d_ax : d_ax;
  assign sat    = mag <= SAT_LIM;
  assign bidx   = CW'(WIDTH-1) - cnt_q;
  assign trial  = {rem_q, DLO[bidx]};
  assign ge     = trial >= {1'b0, mag};
  assign last   = cnt_q == CW'(WIDTH-1);
  assign qfin   = {quo_q[WIDTH-2:0], ge};
  // Saturated axes still run all WIDTH steps so latency never depends on data.
  assign mres   = sat ? MAXP : qfin;
  assign res    = neg ? -mres : mres;
  assign accept = state_q == IDLE && alive_q && rs.in_valid;
  always_comb begin
    state_d  = state_q;
    axis_d   = axis_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    orig_d   = orig_q;
    dir_d    = dir_q;
    invdir_d = invdir_q;
    min_t_d  = min_t_q;
    max_t_d  = max_t_q;
    pi_d     = pi_q;
    if (accept) begin
      state_d = DIV;
      orig_d  = rs.in_orig;
      dir_d   = rs.in_dir;
      min_t_d = rs.in_min_t;
      max_t_d = rs.in_max_t;
      pi_d    = rs.in_pi;
      axis_d  = '0;
      cnt_d   = '0;
      rem_d   = REM0;
      quo_d   = '0;
    end
    if (state_q == DIV) begin
      rem_d = ge ? WIDTH'(trial - {1'b0, mag}) : trial[WIDTH-1:0];
      quo_d = qfin;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        invdir_d[WIDTH*axis_q +: WIDTH] = res;
        cnt_d   = '0;
        rem_d   = REM0;
        quo_d   = '0;
        axis_d  = axis_q + 2'd1;
        state_d = axis_q == 2'd2 ? DONE : DIV;
      end
    end
    if (state_q == DONE && rs.out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q  <= IDLE;
      alive_q  <= 1'b0;
      axis_q   <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      orig_q   <= '0;
      dir_q    <= '0;
      invdir_q <= '0;
      min_t_q  <= '0;
      max_t_q  <= '0;
      pi_q     <= '0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      axis_q   <= axis_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      orig_q   <= orig_d;
      dir_q    <= dir_d;
      invdir_q <= invdir_d;
      min_t_q  <= min_t_d;
      max_t_q  <= max_t_d;
      pi_q     <= pi_d;
    end
  assign rs.in_ready   = alive_q && state_q == IDLE;
  assign rs.out_valid  = state_q == DONE;
  assign rs.out_orig   = orig_q;
  assign rs.out_dir    = dir_q;
  assign rs.out_invdir = invdir_q;
  assign rs.out_min_t  = min_t_q;
  assign rs.out_max_t  = max_t_q;
  assign rs.out_pi     = pi_q;
`ifdef RAYSETUP_PERF_CNT_EN
  logic [31:0] perf_rays_q, perf_rays_d, perf_sat_q, perf_sat_d;
  always_comb begin
    perf_rays_d = perf_rays_q + {31'd0, state_q == DONE && rs.out_ready};
    perf_sat_d  = perf_sat_q + {31'd0, state_q == DIV && last && sat};
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      perf_rays_q <= '0;
      perf_sat_q  <= '0;
    end else begin
      perf_rays_q <= perf_rays_d;
      perf_sat_q  <= perf_sat_d;
    end
  assign perf_rays = perf_rays_q;
  assign perf_sat  = perf_sat_q;
`endif
endmodule

// File: tb/tb_ray_setup_invdir.sv
// tb_ray_setup_invdir: directed self-checking bench for ray_setup_invdir
module tb_ray_setup_invdir;
  localparam int W = 32;
  localparam int PW = 16;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic cap_en = 1'b0;
  logic [95:0] cap[$];
`ifdef RAYSETUP_PERF_CNT_EN
  logic [31:0] perf_rays, perf_sat;
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  ray_setup_invdir_if #(.WIDTH(W), .PI_WIDTH(PW)) bus ();
  ray_setup_invdir #(.WIDTH(W), .FRAC(16), .PI_WIDTH(PW)) dut (
    .clk(clk),
    .resetn(resetn),
    .rs(bus)
`ifdef RAYSETUP_PERF_CNT_EN
    ,
    .perf_rays(perf_rays),
    .perf_sat(perf_sat)
`endif
  );
  always @(negedge clk)
    if (cap_en && bus.out_valid && bus.out_ready) cap.push_back(bus.out_invdir);
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // lat counts clock edges from the accepting edge (inclusive) to the edge raising out_valid.
  task automatic run_ray(input logic [95:0] o, input logic [95:0] d, input logic [31:0] mn,
                         input logic [31:0] mx, input logic [15:0] p, output int lat);
    int n;
    @(negedge clk);
    bus.in_orig = o;
    bus.in_dir = d;
    bus.in_min_t = mn;
    bus.in_max_t = mx;
    bus.in_pi = p;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic handshake(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_valid_ready_after"}, {94'd0, bus.out_valid, bus.in_ready}, 96'b01);
  endtask
  initial begin
    int lat, n;
    int acc[3];
    logic [95:0] dirs[3];
    logic [95:0] exps[3];
`ifdef RAYSETUP_PERF_CNT_EN
    logic [31:0] p0;
`endif
    bus.in_valid = 1'b0;
    bus.in_orig = '0;
    bus.in_dir = '0;
    bus.in_min_t = '0;
    bus.in_max_t = '0;
    bus.in_pi = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {95'd0, bus.in_ready}, 96'd0);
    chk("rst_out_valid", {95'd0, bus.out_valid}, 96'd0);
    chk("rst_invdir", bus.out_invdir, 96'd0);
    chk("rst_pi", {80'd0, bus.out_pi}, 96'd0);
    resetn = 1'b1;
    #1 chk("release_in_ready_low", {95'd0, bus.in_ready}, 96'd0);
    @(posedge clk);
    #1 chk("release_in_ready_high", {95'd0, bus.in_ready}, 96'd1);
    run_ray(96'd0, {32'h0000_8000, 32'hFFFE_0000, 32'h0001_0000}, 32'd0, 32'h8000_0000, 16'd1, lat);
    chk("basic_latency", 96'(lat), 96'd97);
    chk("basic_invdir", bus.out_invdir, {32'h0002_0000, 32'hFFFF_8000, 32'h0001_0000});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_invdir", bus.out_invdir, {32'h0002_0000, 32'hFFFF_8000, 32'h0001_0000});
      chk("bp_valid_ready", {94'd0, bus.out_valid, bus.in_ready}, 96'b10);
    end
    handshake("bp");
    run_ray(96'd0, {32'd2, 32'hFFFF_FFFF, 32'd0}, 32'd0, 32'd0, 16'd2, lat);
    chk("sat_latency", 96'(lat), 96'd97);
    chk("sat_invdir", bus.out_invdir, {32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF});
`ifdef RAYSETUP_PERF_CNT_EN
    chk("perf_sat", {64'd0, perf_sat}, 96'd3);
`endif
    handshake("sat");
    run_ray({32'd3, 32'd2, 32'd1}, {32'hFFFF_FFFD, 32'h8000_0000, 32'd3},
            32'h0001_0000, 32'h8000_0000, 16'h0005, lat);
    chk("pt_latency", 96'(lat), 96'd97);
    chk("pt_invdir", bus.out_invdir, {32'hAAAA_AAAB, 32'hFFFF_FFFE, 32'h5555_5555});
    chk("pt_orig", bus.out_orig, {32'd3, 32'd2, 32'd1});
    chk("pt_dir", bus.out_dir, {32'hFFFF_FFFD, 32'h8000_0000, 32'd3});
    chk("pt_min_t", {64'd0, bus.out_min_t}, 96'h0001_0000);
    chk("pt_max_t", {64'd0, bus.out_max_t}, 96'h8000_0000);
    chk("pt_pi", {80'd0, bus.out_pi}, 96'h0005);
    handshake("pt");
    @(negedge clk);
    bus.in_dir = {32'd7, 32'd7, 32'd7};
    bus.in_pi = 16'h0009;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1 resetn = 1'b0;
    #1 chk("midrst_valid_ready", {94'd0, bus.out_valid, bus.in_ready}, 96'b00);
    chk("midrst_pi", {80'd0, bus.out_pi}, 96'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_ray(96'd0, {32'h0001_0000, 32'h0001_0000, 32'h0001_0000}, 32'd0, 32'd0, 16'd3, lat);
    chk("midrst_latency", 96'(lat), 96'd97);
    chk("midrst_invdir", bus.out_invdir, {32'h0001_0000, 32'h0001_0000, 32'h0001_0000});
    handshake("midrst");
    dirs[0] = {32'h0004_0000, 32'h0004_0000, 32'h0004_0000};
    exps[0] = {32'h0000_4000, 32'h0000_4000, 32'h0000_4000};
    dirs[1] = {32'h0000_8000, 32'h0001_0000, 32'hFFFF_0000};
    exps[1] = {32'h0002_0000, 32'h0001_0000, 32'hFFFF_0000};
    dirs[2] = {32'd7, 32'd1, 32'h0008_0000};
    exps[2] = {32'h2492_4924, 32'h7FFF_FFFF, 32'h0000_2000};
`ifdef RAYSETUP_PERF_CNT_EN
    p0 = perf_rays;
`endif
    @(negedge clk);
    bus.out_ready = 1'b1;
    cap_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_dir = dirs[k];
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      acc[k] = cyc;
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (cap.size() < 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_count", 96'(cap.size()), 96'd3);
    chk("b2b_gap01", 96'(acc[1] - acc[0]), 96'd98);
    chk("b2b_gap12", 96'(acc[2] - acc[1]), 96'd98);
    for (int k = 0; k < 3; k++)
      chk("b2b_invdir", cap.size() > k ? cap[k] : 96'd0, exps[k]);
`ifdef RAYSETUP_PERF_CNT_EN
    chk("perf_rays", {64'd0, perf_rays - p0}, 96'd3);
`endif
    bus.out_ready = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
